// File: rtl/seg_pkg.sv
// Shared defaults, row-controller state encoding and signed saturation limits
// for the segmentation dynamic-programming datapath.
package seg_pkg;

   localparam int BIT_WIDTH_DEF = 32;
   localparam int I_DEF         = 160;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN
   } seg_state_t;

   // Limits are returned 64 bits wide; callers truncate to their own width.
   function automatic logic signed [63:0] sat_hi(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_lo(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

endpackage

// File: rtl/sat_add.sv
// Signed adder that clamps to the most positive / most negative value on
// overflow instead of wrapping.
module sat_add
   import seg_pkg::*;
#(
   parameter int WIDTH = BIT_WIDTH_DEF
) (
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic signed [WIDTH-1:0] sum
);

   localparam logic signed [WIDTH-1:0] MAX_V = WIDTH'(sat_hi(WIDTH));
   localparam logic signed [WIDTH-1:0] MIN_V = WIDTH'(sat_lo(WIDTH));

   logic [WIDTH:0] full;

   // NOTE: every output of a combinational block gets a default first, so no
   // path through it can leave a value held and infer a latch.
   always_comb begin
      full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      sum  = full[WIDTH-1:0];
      if (full[WIDTH] != full[WIDTH-1]) begin
         sum = full[WIDTH] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/seg_dp.sv
// Per-row minimum-cost recurrence C(i) = min_j C(j-1) + E_min(j,i) with argmin
// backpointers, fed by a strictly ordered beat stream and a 3-stage pipeline.
module seg_dp
   import seg_pkg::*;
#(
   parameter  int BIT_WIDTH = BIT_WIDTH_DEF,
   parameter  int I         = I_DEF,
   localparam int IW        = $clog2(I)
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        start_in,
   input  logic [IW-1:0]               i_in,
   input  logic [IW-1:0]               j_in,
   input  logic signed [BIT_WIDTH-1:0] emin_in,
   input  logic                        emin_valid_in,
   output logic                        busy_out,
   output logic                        row_done_out,
   output logic signed [BIT_WIDTH-1:0] cost_out,
   output logic [IW-1:0]               bp_out,
   input  logic [IW-1:0]               rd_addr_in,
   output logic [IW-1:0]               rd_bp_out,
   output logic                        error_out
);

   localparam logic signed [BIT_WIDTH-1:0] MAX_V = BIT_WIDTH'(sat_hi(BIT_WIDTH));
   localparam logic [IW-1:0]               ONE_J = IW'(1);
   localparam logic [IW:0]                 I_LIM = (IW + 1)'(I);

   seg_state_t                  state;
   logic signed [BIT_WIDTH-1:0] cost [0:I-1];
   logic [IW-1:0]               bp   [0:I-1];

   logic [IW-1:0]               row_i, exp_j, min_j;
   logic signed [BIT_WIDTH-1:0] min_v;

   logic                        s0_valid, s0_last;
   logic [IW-1:0]               s0_j;
   logic signed [BIT_WIDTH-1:0] s0_emin, s0_p;
   logic                        s1_valid, s1_last;
   logic [IW-1:0]               s1_j;
   logic signed [BIT_WIDTH-1:0] s1_sum;

   logic signed [BIT_WIDTH-1:0] sum_c, new_min;
   logic [IW-1:0]               new_j;
   logic                        beat_ok, take_new;

   sat_add #(.WIDTH(BIT_WIDTH)) u_sat_add (
      .a   (s0_p),
      .b   (s0_emin),
      .sum (sum_c)
   );

   assign busy_out = (state != IDLE);
   assign beat_ok  = (state == ACCUM) && emin_valid_in && (j_in == exp_j);
   // Strict less-than: on a tie the earlier (smaller) j is kept.
   assign take_new = s1_valid && (s1_sum < min_v);
   assign new_min  = take_new ? s1_sum : min_v;
   assign new_j    = take_new ? s1_j : min_j;

   // NOTE: all state here uses non-blocking assignments so every register
   // samples the pre-edge value of every other, independent of statement order.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         row_done_out <= 1'b0;
         error_out    <= 1'b0;
         cost_out     <= '0;
         bp_out       <= '0;
         rd_bp_out    <= '0;
         row_i        <= '0;
         exp_j        <= '0;
         min_j        <= '0;
         min_v        <= '0;
         s0_valid     <= 1'b0;
         s0_last      <= 1'b0;
         s0_j         <= '0;
         s0_emin      <= '0;
         s0_p         <= '0;
         s1_valid     <= 1'b0;
         s1_last      <= 1'b0;
         s1_j         <= '0;
         s1_sum       <= '0;
         // NOTE: the tables are cleared by reset because later rows read
         // unwritten entries as zero; this forces flops rather than RAM.
         for (int k = 0; k < I; k++) begin
            cost[k] <= '0;
            bp[k]   <= '0;
         end
      end else begin
         row_done_out <= 1'b0;

         s0_valid <= beat_ok;
         s0_last  <= beat_ok && (j_in == row_i);
         s0_j     <= j_in;
         s0_emin  <= emin_in;
         s0_p     <= (j_in == '0) ? '0 : cost[j_in - ONE_J];

         s1_valid <= s0_valid;
         s1_last  <= s0_last;
         s1_j     <= s0_j;
         s1_sum   <= sum_c;

         if (s1_valid) begin
            min_v <= new_min;
            min_j <= new_j;
         end
         if (s1_valid && s1_last) begin
            cost[row_i]  <= new_min;
            bp[row_i]    <= new_j;
            row_done_out <= 1'b1;
            cost_out     <= new_min;
            bp_out       <= new_j;
         end

         rd_bp_out <= ({1'b0, rd_addr_in} < I_LIM) ? bp[rd_addr_in] : '0;

         case (state)
            IDLE: begin
               if (start_in) begin
                  if ({1'b0, i_in} < I_LIM) begin
                     state <= ACCUM;
                     row_i <= i_in;
                     exp_j <= '0;
                     min_v <= MAX_V;
                     min_j <= '0;
                  end else begin
                     error_out <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (emin_valid_in) begin
                  if (beat_ok) begin
                     exp_j <= exp_j + ONE_J;
                     if (j_in == row_i) state <= DRAIN;
                  end else begin
                     error_out <= 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (row_done_out) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
